ocd_lvl_ramp: RTL and testbench

- Upstream source for the over-current-detect level PWM. It produces the `pw_par` word consumed by the OCD level DAC stage.
- Accepts new OCD level targets over a valid/ready handshake. Targets above `PAR_MAX_VAL` are clamped.
- Increases are slew-limited: one LSB per tick, so the analog threshold after the RC filter never jumps up.
- Decreases are applied immediately, because a lower trip level is always the safe direction.

---
 rtl/ocd_lvl_ramp.sv | 121 ++++++++++++
 tb/tb_ocd_lvl_ramp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ocd_lvl_ramp.sv
// OCD level ramp: takes clamped level targets over valid/ready and drives pw_par,
// raising it one LSB per prescaler tick and dropping it at once on a lower target.
module ocd_lvl_ramp #(
    parameter int CLK_MHZ     = 100,
    parameter int PAR_MAX_VAL = 255,
    parameter int STEP_US     = 50,
    parameter int PAR_INIT    = 0,
    localparam int W          = (PAR_MAX_VAL < 1) ? 1 : $clog2(PAR_MAX_VAL + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W:0]   tgt_par,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    output logic [W-1:0] pw_par,
    output logic         settled,
    output logic         clamped,
    output logic [1:0]   state_dbg
);

    localparam int TICK_CYC = (CLK_MHZ * STEP_US < 1) ? 1 : CLK_MHZ * STEP_US;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);
    localparam logic [W:0]    MAX_EXT   = (W + 1)'(PAR_MAX_VAL);
    localparam logic [W-1:0]  INIT_VAL  = W'(PAR_INIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  pw_q, pw_d;
    logic [W-1:0]  tgt_q, tgt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ready_q, ready_d;
    logic          settled_q, settled_d;
    logic          clamped_q, clamped_d;

    logic          accept;
    logic          over;
    logic [W:0]    pw_inc;

    // Valid/ready: a request is taken on any edge where tgt_valid && tgt_ready;
    // the requester holds tgt_par/tgt_valid stable until that edge.
    assign accept = tgt_valid && ready_q;
    assign over   = (tgt_par > MAX_EXT);
    assign pw_inc = {1'b0, pw_q} + (W + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pw_q      <= INIT_VAL;
            tgt_q     <= INIT_VAL;
            presc_q   <= '0;
            ready_q   <= 1'b0;
            settled_q <= 1'b1;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pw_q      <= pw_d;
            tgt_q     <= tgt_d;
            presc_q   <= presc_d;
            ready_q   <= ready_d;
            settled_q <= settled_d;
            clamped_q <= clamped_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        tgt_d   = tgt_q;
        presc_d = presc_q;

        case (state_q)
            IDLE: presc_d = '0;
            LOAD: begin
                presc_d = '0;
                if (tgt_q < pw_q) begin
                    pw_d    = tgt_q;
                    state_d = IDLE;
                end else if (tgt_q == pw_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    pw_d    = pw_inc[W-1:0];
                    if (pw_inc == {1'b0, tgt_q}) state_d = IDLE;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh request wins over a tick landing on the same edge.
        if (accept) begin
            tgt_d   = over ? MAX_EXT[W-1:0] : tgt_par[W-1:0];
            state_d = LOAD;
            presc_d = '0;
            pw_d    = pw_q;
        end

        ready_d   = (state_d != LOAD);
        settled_d = (state_d == IDLE);
        clamped_d = accept && over;
    end

    assign tgt_ready = ready_q;
    assign pw_par    = pw_q;
    assign settled   = settled_q;
    assign clamped   = clamped_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ocd_lvl_ramp.sv
// Bench for ocd_lvl_ramp: directed scenarios plus random targets, checked every
// cycle against a closed-form level model (base + elapsed/TICK, capped at target).
module tb_ocd_lvl_ramp;

    localparam int TICK = 10;
    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] tgt_par = '0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [7:0] pw_par;
    logic       settled;
    logic       clamped;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // model: level at start of the current segment, its target, current expected level
    int m_base = 0;
    int m_tgt  = 0;
    int m_pw   = 0;

    ocd_lvl_ramp #(
        .CLK_MHZ(10),
        .PAR_MAX_VAL(255),
        .STEP_US(1),
        .PAR_INIT(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tgt_par(tgt_par),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .pw_par(pw_par),
        .settled(settled),
        .clamped(clamped),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Present a request at the current negedge; check the LOAD cycle that follows.
    task automatic do_accept(input int v);
        int waited = 0;
        while (!tgt_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (tgt_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_ready_wait: tgt_ready=%b, required 1", tgt_ready);
        end
        tgt_par   = 9'(v);
        tgt_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // garbage while not ready must be ignored
        tgt_par = 9'($urandom_range(0, 511));
        n_checks++;
        if (tgt_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL load_ready: tgt_ready=%b, required 0", tgt_ready);
        end
        n_checks++;
        if (settled !== 1'b0) begin
            n_errors++;
            $display("FAIL load_settled: settled=%b, required 0", settled);
        end
        n_checks++;
        if (clamped !== ((v > MAXV) ? 1'b1 : 1'b0)) begin
            n_errors++;
            $display("FAIL load_clamped: clamped=%b, required %0d (req %0d)", clamped, v > MAXV, v);
        end
        n_checks++;
        if (pw_par !== 8'(m_pw)) begin
            n_errors++;
            $display("FAIL load_pw: pw_par=%0d, required %0d", pw_par, m_pw);
        end
        m_base = m_pw;
        m_tgt  = (v > MAXV) ? MAXV : v;
    endtask

    // Check n cycles after LOAD; k counts clock edges since the end of LOAD.
    task automatic follow(input int n);
        int exp_pw;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
            if (m_tgt <= m_base) exp_pw = m_tgt;
            else exp_pw = (m_base + k / TICK > m_tgt) ? m_tgt : m_base + k / TICK;
            m_pw = exp_pw;
            n_checks++;
            if (pw_par !== 8'(exp_pw)) begin
                n_errors++;
                $display("FAIL pw_par k=%0d: got %0d, required %0d (base %0d tgt %0d)",
                         k, pw_par, exp_pw, m_base, m_tgt);
            end
            n_checks++;
            if (settled !== ((exp_pw == m_tgt) ? 1'b1 : 1'b0)) begin
                n_errors++;
                $display("FAIL settled k=%0d: got %b, required %0d", k, settled, exp_pw == m_tgt);
            end
            n_checks++;
            if (tgt_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL tgt_ready k=%0d: got %b, required 1", k, tgt_ready);
            end
            n_checks++;
            if (clamped !== 1'b0) begin
                n_errors++;
                $display("FAIL clamped_idle k=%0d: got %b, required 0", k, clamped);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pw_par !== 8'd0 || settled !== 1'b1 || tgt_ready !== 1'b0 || clamped !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: pw=%0d settled=%b ready=%b clamped=%b, required 0 1 0 0",
                     pw_par, settled, tgt_ready, clamped);
        end
        rst_n = 1'b1;
        m_base = 0;
        m_tgt  = 0;
        m_pw   = 0;
        follow(20);
    endtask

    task automatic test_ramp_up;
        do_accept(5);
        follow(60);
    endtask

    task automatic test_fall;
        do_accept(200);
        follow(1960);
        do_accept(40);
        follow(30);
    endtask

    task automatic test_clamp;
        do_accept(0);
        follow(5);
        do_accept(300);
        follow(2560);
    endtask

    task automatic test_mid_ramp;
        do_accept(0);
        follow(3);
        do_accept(20);
        follow(73);
        do_accept(3);
        follow(15);
        do_accept(9);
        follow(70);
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            do_accept(int'($urandom_range(0, 300)));
            follow(int'($urandom_range(1, 400)));
        end
    endtask

    task automatic test_reset_mid_ramp;
        do_accept(0);
        follow(3);
        do_accept(30);
        follow(121);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pw_par !== 8'd0) begin
            n_errors++;
            $display("FAIL async_reset_pw: pw_par=%0d, required 0", pw_par);
        end
        n_checks++;
        if (settled !== 1'b1 || tgt_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset_flags: settled=%b ready=%b, required 1 0", settled, tgt_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_base = 0;
        m_tgt  = 0;
        m_pw   = 0;
        follow(40);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_fall();
        test_clamp();
        test_mid_ramp();
        test_random();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
